// File: rtl/can_rx_fifo_if.sv
// Signal bundle between the CAN core / host and the receive FIFO.
// The FIFO takes the slave view; the core and host side take the master view.
interface can_rx_fifo_if #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned FRAMES = 32
);
  localparam int unsigned FCW = $clog2(FRAMES) + 1;
  localparam int unsigned BCW = $clog2(DEPTH) + 1;

  logic           wr;
  logic [7:0]     data_in;
  logic           frame_done;
  logic           frame_abort;
  logic           release_buffer;
  logic           clear_overrun;
  logic [3:0]     rd_addr;
  logic [7:0]     data_out;
  logic           rx_avail;
  logic           overrun;
  logic [FCW-1:0] frame_count;
  logic [BCW-1:0] byte_count;

  modport slave (
    input  wr, data_in, frame_done, frame_abort, release_buffer, clear_overrun, rd_addr,
    output data_out, rx_avail, overrun, frame_count, byte_count
  );

  modport master (
    output wr, data_in, frame_done, frame_abort, release_buffer, clear_overrun, rd_addr,
    input  data_out, rx_avail, overrun, frame_count, byte_count
  );
endinterface

// File: rtl/can_rx_fifo.sv
// CAN receive FIFO: circular byte store plus a queue of committed frame lengths.
// The host reads the oldest committed frame by offset and releases it when done.
module can_rx_fifo #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned FRAMES  = 32,
  parameter int unsigned MAX_LEN = 13
) (
  input  logic         clk,
  input  logic         rst,
  can_rx_fifo_if.slave bus
);
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned FW  = $clog2(FRAMES);
  localparam int unsigned BCW = AW + 1;
  localparam int unsigned FCW = FW + 1;
  localparam int unsigned LW  = 4;

  logic [7:0]     mem_q  [DEPTH];
  logic [LW-1:0]  info_q [FRAMES];

  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]  cur_len_q, cur_len_d;
  logic           bad_q, bad_d;
  logic [FW-1:0]  head_q, head_d;
  logic [FW-1:0]  tail_q, tail_d;
  logic [FCW-1:0] frame_count_q, frame_count_d;
  logic [BCW-1:0] byte_count_q, byte_count_d;
  logic [7:0]     data_out_q, data_out_d;
  logic           rx_avail_q, rx_avail_d;
  logic           overrun_q, overrun_d;

  logic           wr_ok_c, wr_drop_c, bad_eff_c, q_full_c;
  logic           close_c, commit_c, discard_c, release_ok_c, ovr_set_c;
  logic [LW-1:0]  len_eff_c, head_len_c;
  logic [AW-1:0]  rd_idx_c;

  // Event decode; a byte arriving with a close pulse belongs to the closing frame.
  always_comb begin
    head_len_c   = info_q[head_q];
    q_full_c     = (frame_count_q == FCW'(FRAMES));
    wr_ok_c      = bus.wr && (byte_count_q != BCW'(DEPTH)) &&
                   (cur_len_q != LW'(MAX_LEN)) && !bad_q;
    wr_drop_c    = bus.wr && !wr_ok_c;
    len_eff_c    = cur_len_q + LW'(wr_ok_c);
    bad_eff_c    = bad_q | wr_drop_c;
    close_c      = bus.frame_done | bus.frame_abort;
    commit_c     = bus.frame_done && !bus.frame_abort && (len_eff_c != '0) &&
                   !bad_eff_c && !q_full_c;
    discard_c    = close_c && !commit_c;
    release_ok_c = bus.release_buffer && (frame_count_q != '0);
    ovr_set_c    = wr_drop_c | (bus.frame_done && !bus.frame_abort && q_full_c &&
                                (len_eff_c != '0) && !bad_eff_c);
    rd_idx_c     = rd_ptr_q + AW'(bus.rd_addr);
  end

  // Next-state computation for pointers, counters and flags.
  always_comb begin
    wr_ptr_d      = wr_ptr_q + AW'(wr_ok_c);
    rd_ptr_d      = rd_ptr_q;
    cur_len_d     = len_eff_c;
    bad_d         = bad_eff_c;
    head_d        = head_q;
    tail_d        = tail_q + FW'(commit_c);
    byte_count_d  = byte_count_q + BCW'(wr_ok_c);
    frame_count_d = frame_count_q + FCW'(commit_c) - FCW'(release_ok_c);
    overrun_d     = overrun_q;
    data_out_d    = '0;

    if (discard_c) begin
      wr_ptr_d     = wr_ptr_d - AW'(len_eff_c);
      byte_count_d = byte_count_d - BCW'(len_eff_c);
    end
    if (close_c) begin
      cur_len_d = '0;
      bad_d     = 1'b0;
    end
    if (release_ok_c) begin
      rd_ptr_d     = rd_ptr_q + AW'(head_len_c);
      head_d       = head_q + FW'(1);
      byte_count_d = byte_count_d - BCW'(head_len_c);
    end

    rx_avail_d = (frame_count_d != '0);

    if (ovr_set_c)              overrun_d = 1'b1;
    else if (bus.clear_overrun) overrun_d = 1'b0;

    if ((frame_count_q != '0) && (bus.rd_addr < head_len_c))
      data_out_d = mem_q[rd_idx_c];
  end

  // Control state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cur_len_q     <= '0;
      bad_q         <= 1'b0;
      head_q        <= '0;
      tail_q        <= '0;
      frame_count_q <= '0;
      byte_count_q  <= '0;
      data_out_q    <= '0;
      rx_avail_q    <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cur_len_q     <= cur_len_d;
      bad_q         <= bad_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      frame_count_q <= frame_count_d;
      byte_count_q  <= byte_count_d;
      data_out_q    <= data_out_d;
      rx_avail_q    <= rx_avail_d;
      overrun_q     <= overrun_d;
    end
  end

  // Storage arrays carry no reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_ok_c)  mem_q[wr_ptr_q] <= bus.data_in;
    if (commit_c) info_q[tail_q]  <= len_eff_c;
  end

  assign bus.data_out    = data_out_q;
  assign bus.rx_avail    = rx_avail_q;
  assign bus.overrun     = overrun_q;
  assign bus.frame_count = frame_count_q;
  assign bus.byte_count  = byte_count_q;

endmodule
